// File: rtl/glitch_pulse_gen.sv
// Trigger-to-glitch timing stage: synchronizes an external trigger, waits a programmed
// delay, then emits N enable pulses of width W separated by gaps of G cycles.
module glitch_pulse_gen #(
    parameter int DELAY_W     = 16,
    parameter int WIDTH_W     = 8,
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_in,
    input  logic               trig_edge,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [WIDTH_W-1:0] cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic [3:0]         cfg_mode,
    output logic               glitch_en,
    output logic [3:0]         glitch_mode,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pulse_cnt,
    output logic [2:0]         dbg_state
);

    localparam int TMR_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_hist;
    logic                     r_edge;
    logic                     w_sync;
    logic                     w_edge;

    logic [DELAY_W-1:0]       r_delay;
    logic [WIDTH_W-1:0]       r_width;
    logic [WIDTH_W-1:0]       r_gap;
    logic [COUNT_W-1:0]       r_count;
    logic [3:0]               r_mode;

    logic [TMR_W-1:0]         r_tmr;
    logic                     w_tmr_zero;
    logic                     w_tmr_load;
    logic [TMR_W-1:0]         w_tmr_val;

    logic [COUNT_W-1:0]       r_pulse_cnt;
    logic                     r_glitch_en;
    logic                     r_done;

    logic                     w_arm_accept;
    logic                     w_pulse_start;
    logic                     w_done_set;

    logic [WIDTH_W-1:0]       w_width_eff;
    logic [WIDTH_W-1:0]       w_gap_eff;
    logic [COUNT_W-1:0]       w_count_eff;

    // Zero-valued width/gap/count are promoted to one so every train makes progress.
    assign w_width_eff = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
    assign w_gap_eff   = (cfg_gap   == '0) ? WIDTH_W'(1) : cfg_gap;
    assign w_count_eff = (cfg_count == '0) ? COUNT_W'(1) : cfg_count;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_edge = trig_edge ? (r_hist & ~w_sync) : (~r_hist & w_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], trig_in};
            r_hist <= w_sync;
            // Only edges seen while waiting in ARMED may start a train.
            r_edge <= w_edge & (r_state == S_ARMED) & ~abort;
        end
    end

    assign w_tmr_zero   = (r_tmr == '0);
    assign w_arm_accept = (r_state == S_IDLE) & arm & ~abort;

    always_comb begin
        w_next        = r_state;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_pulse_start = 1'b0;
        w_done_set    = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) w_next = S_ARMED;
                end
                S_ARMED: begin
                    if (r_edge) begin
                        if (r_delay == '0) begin
                            w_next        = S_PULSE;
                            w_tmr_load    = 1'b1;
                            w_tmr_val     = TMR_W'(r_width - WIDTH_W'(1));
                            w_pulse_start = 1'b1;
                        end else begin
                            w_next     = S_DELAY;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TMR_W'(r_delay - DELAY_W'(1));
                        end
                    end
                end
                S_DELAY: begin
                    if (w_tmr_zero) begin
                        w_next        = S_PULSE;
                        w_tmr_load    = 1'b1;
                        w_tmr_val     = TMR_W'(r_width - WIDTH_W'(1));
                        w_pulse_start = 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_tmr_zero) begin
                        if (r_pulse_cnt == r_count) begin
                            w_next     = S_IDLE;
                            w_done_set = 1'b1;
                        end else begin
                            w_next     = S_GAP;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TMR_W'(r_gap - WIDTH_W'(1));
                        end
                    end
                end
                S_GAP: begin
                    if (w_tmr_zero) begin
                        w_next        = S_PULSE;
                        w_tmr_load    = 1'b1;
                        w_tmr_val     = TMR_W'(r_width - WIDTH_W'(1));
                        w_pulse_start = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Down-counter: loaded with length-1 on state entry, phase ends when it hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (w_tmr_load) begin
            r_tmr <= w_tmr_val;
        end else if (!w_tmr_zero) begin
            r_tmr <= r_tmr - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay <= '0;
            r_width <= WIDTH_W'(1);
            r_gap   <= WIDTH_W'(1);
            r_count <= COUNT_W'(1);
            r_mode  <= 4'd0;
        end else if (w_arm_accept) begin
            r_delay <= cfg_delay;
            r_width <= w_width_eff;
            r_gap   <= w_gap_eff;
            r_count <= w_count_eff;
            r_mode  <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= '0;
            r_glitch_en <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_arm_accept) begin
                r_pulse_cnt <= '0;
            end else if (w_pulse_start) begin
                r_pulse_cnt <= r_pulse_cnt + COUNT_W'(1);
            end
            // Enable is the registered image of the PULSE state, so it never glitches.
            r_glitch_en <= (w_next == S_PULSE);
            r_done      <= w_done_set;
        end
    end

    assign glitch_en   = r_glitch_en;
    assign glitch_mode = r_mode;
    assign armed       = (r_state == S_ARMED);
    assign busy        = (r_state == S_DELAY) | (r_state == S_PULSE) | (r_state == S_GAP);
    assign done        = r_done;
    assign pulse_cnt   = r_pulse_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: directed scenario table, hand-written corner sequences,
// then randomized traffic against a timing-arithmetic reference model.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_in = 1'b0;
  logic        trig_edge = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_gap = '0;
  logic [7:0]  cfg_count = '0;
  logic [3:0]  cfg_mode = '0;
  logic        glitch_en;
  logic [3:0]  glitch_mode;
  logic        armed;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  glitch_pulse_gen #(
    .DELAY_W(16), .WIDTH_W(8), .COUNT_W(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
    .trig_edge(trig_edge), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_mode(cfg_mode),
    .glitch_en(glitch_en), .glitch_mode(glitch_mode), .armed(armed), .busy(busy),
    .done(done), .pulse_cnt(pulse_cnt), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // driver tasks: inputs change only at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_arm(input int d, input int w, input int g, input int n, input logic [3:0] m);
    cfg_delay = 16'(d); cfg_width = 8'(w); cfg_gap = 8'(g); cfg_count = 8'(n); cfg_mode = m;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // reference model: train timing from start edge by plain arithmetic
  int   m_ph, m_t, m_d, m_w, m_g, m_n, m_cnt;
  logic [3:0] m_mode;
  bit   m_pend, e_en, e_done;
  bit   m_hist[3];

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_d = 0; m_w = 1; m_g = 1; m_n = 1; m_cnt = 0; m_mode = '0;
    m_pend = 0; e_en = 0; e_done = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 0;
  endtask

  // called right after each rising edge; m_hist[i] = trig sampled i+1 edges ago
  task automatic model_edge();
    bit det, nxt_pend;
    int o, p;
    det = trig_edge ? (m_hist[2] && !m_hist[1]) : (!m_hist[2] && m_hist[1]);
    nxt_pend = det && (m_ph == 1) && !abort;
    e_en = 0; e_done = 0;
    if (abort) m_ph = 0;
    else if (m_ph == 0 && arm) begin
      m_ph = 1; m_cnt = 0; m_mode = cfg_mode;
      m_d = int'(cfg_delay);
      m_w = (cfg_width == 0) ? 1 : int'(cfg_width);
      m_g = (cfg_gap == 0) ? 1 : int'(cfg_gap);
      m_n = (cfg_count == 0) ? 1 : int'(cfg_count);
    end
    else if (m_ph == 1 && m_pend) begin m_ph = 2; m_t = 0; end
    else if (m_ph == 2) m_t++;
    if (m_ph == 2) begin
      o = m_t - m_d;
      if (o >= 0) begin
        p = m_w + m_g;
        m_cnt = o / p + 1;
        if ((o / p == m_n - 1) && (o % p == m_w)) begin m_ph = 0; e_done = 1; end
        else e_en = (o % p < m_w);
      end
    end
    m_pend = nxt_pend;
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = trig_in;
  endtask

  // directed scenario table
  typedef struct {
    bit   edge_sel;
    bit   pre;
    int   d, w, g, n;
    logic [3:0] mode;
    int   exp_first, exp_high, exp_rises, exp_done_edge, exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input int idx, input vec_t v);
    int first, highs, rises, dones, done_edge;
    bit prev;
    trig_edge = v.edge_sel;
    trig_in   = v.edge_sel ^ v.pre;
    repeat (5) tick();
    do_arm(v.d, v.w, v.g, v.n, v.mode);
    check($sformatf("v%0d_armed", idx), armed, 1'b1);
    if (v.pre) begin
      trig_in = ~trig_in;
      repeat (8) tick();
      check($sformatf("v%0d_wrong_edge_ignored", idx), {busy, glitch_en, armed}, 3'b001);
    end
    trig_in = ~trig_in;
    first = -1; highs = 0; rises = 0; dones = 0; done_edge = -1; prev = 0;
    for (int j = 0; j < 400; j++) begin
      tick();
      if (glitch_en && first < 0) first = j;
      if (glitch_en) highs++;
      if (glitch_en && !prev) rises++;
      prev = glitch_en;
      if (done) begin dones++; done_edge = j; end
      if (done_edge >= 0 && j >= done_edge + 3) break;
    end
    check($sformatf("v%0d_first_edge", idx), first, v.exp_first);
    check($sformatf("v%0d_high_cycles", idx), highs, v.exp_high);
    check($sformatf("v%0d_pulses", idx), rises, v.exp_rises);
    check($sformatf("v%0d_done_count", idx), dones, 1);
    check($sformatf("v%0d_done_edge", idx), done_edge, v.exp_done_edge);
    check($sformatf("v%0d_pulse_cnt", idx), pulse_cnt, v.exp_cnt);
    check($sformatf("v%0d_mode", idx), glitch_mode, v.mode);
    check($sformatf("v%0d_idle", idx), {armed, busy}, 2'b00);
  endtask

  initial begin
    int rise2_edge, rises, highs, dones, j;
    bit prev;

    //           edge pre  D   W  G  N  mode    first high rises done cnt
    vecs[0] = '{1'b0, 1'b0, 0,  1, 1, 1, 4'h5,   3,    1,   1,    4,  1};
    vecs[1] = '{1'b0, 1'b0, 10, 4, 3, 3, 4'hA,   13,   12,  3,    31, 3};
    vecs[2] = '{1'b1, 1'b1, 2,  0, 2, 0, 4'h3,   5,    1,   1,    6,  1};
    vecs[3] = '{1'b1, 1'b0, 0,  2, 0, 3, 4'hC,   3,    6,   3,    11, 3};

    // reset state
    repeat (3) tick();
    check("rst_outputs", {glitch_en, armed, busy, done}, 4'b0000);
    check("rst_mode", glitch_mode, 4'd0);
    check("rst_cnt", pulse_cnt, 8'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // abort during 2nd pulse, extra trigger edges while busy
    trig_edge = 1'b0; trig_in = 1'b0;
    repeat (5) tick();
    do_arm(1, 3, 2, 5, 4'h7);
    trig_in = 1'b1;
    rises = 0; prev = 0; rise2_edge = -1;
    for (j = 0; j < 60; j++) begin
      tick();
      if (glitch_en && !prev) rises++;
      prev = glitch_en;
      if (rises >= 1) trig_in = ~trig_in;
      if (rises == 2) begin rise2_edge = j; break; end
    end
    check("abort_second_pulse_edge", rise2_edge, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_en_low", glitch_en, 1'b0);
    check("abort_idle", {armed, busy}, 2'b00);
    check("abort_no_done", done, 1'b0);
    check("abort_cnt_hold", pulse_cnt, 8'd2);
    highs = 0; dones = 0;
    for (int k = 0; k < 20; k++) begin
      trig_in = ~trig_in;
      tick();
      if (glitch_en) highs++;
      if (done) dones++;
    end
    check("abort_no_restart", highs, 0);
    check("abort_no_late_done", dones, 0);

    // arm and abort together in IDLE; arm while busy
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", {armed, busy}, 2'b00);
    trig_in = 1'b0;
    repeat (5) tick();
    do_arm(20, 1, 1, 1, 4'h6);
    trig_in = 1'b1;
    repeat (6) tick();
    check("busy_in_delay", busy, 1'b1);
    do_arm(0, 1, 1, 1, 4'h9);
    check("arm_busy_mode_kept", glitch_mode, 4'h6);
    check("arm_busy_still_busy", {armed, busy}, 2'b01);
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) dones++;
    end
    check("arm_busy_train_done", dones, 1);
    check("arm_busy_final_cnt", pulse_cnt, 8'd1);

    // reset asserted in the middle of a pulse
    trig_in = 1'b0;
    repeat (5) tick();
    do_arm(0, 8, 1, 1, 4'h4);
    trig_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (glitch_en) break;
    end
    check("rst_mid_reached_pulse", glitch_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en", glitch_en, 1'b0);
    check("rst_mid_flags", {armed, busy, done}, 3'b000);
    check("rst_mid_mode", glitch_mode, 4'd0);
    check("rst_mid_cnt", pulse_cnt, 8'd0);
    trig_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    trig_in = 1'b1;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (glitch_en || armed || busy) highs++;
    end
    check("rst_trig_without_arm", highs, 0);

    // randomized traffic against the reference model
    rst_n = 1'b0;
    trig_in = 1'($urandom_range(0, 1));
    tick();
    tick();
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      arm       = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
      if ($urandom_range(0, 199) == 0) trig_edge = ~trig_edge;
      cfg_delay = 16'($urandom_range(0, 5));
      cfg_width = 8'($urandom_range(0, 4));
      cfg_gap   = 8'($urandom_range(0, 4));
      cfg_count = 8'($urandom_range(0, 4));
      cfg_mode  = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("rnd_glitch_en", glitch_en, e_en);
      check("rnd_done", done, e_done);
      check("rnd_armed", armed, (m_ph == 1));
      check("rnd_busy", busy, (m_ph == 2));
      check("rnd_pulse_cnt", pulse_cnt, 8'(m_cnt));
      check("rnd_mode", glitch_mode, m_mode);
    end
    arm = 1'b0; abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
